opc_ram_arbiter: RTL and testbench

Shares the single-port system block RAM between the OPC CPU and one bus-master requester (DMA or serial loader engine). DMA accesses take priority and stall the CPU through its clock-enable. A hold limit guarantees the CPU at least one RAM cycle after every `MAX_HOLD` consecutive DMA cycles. The block sits between the CPU/address decoder and the RAM instance, which is clocked on the falling edge so read data is valid within the same cycle.

---
 rtl/opc_ram_arbiter.sv | 155 +++++++++++++++
 tb/tb_opc_ram_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opc_ram_arbiter.sv
// -----------------------------------------------------------------------------
// opc_ram_arbiter
//
// Purpose:
//   Shares the single-port system block RAM between the OPC CPU and one
//   bus-master requester (DMA or serial loader engine). A pending DMA request
//   owns the RAM in the same cycle it is asserted and stalls the CPU by
//   dropping its clock enable. After every MAX_HOLD consecutive DMA-owned
//   cycles the CPU is handed exactly one RAM cycle, so it can never be starved
//   by a long burst.
//
//   The RAM instance is clocked on the falling edge of clk, so read data
//   appears on ram_dout within the same cycle as the address. The RAM port
//   mux, dma_ack and cpu_clken are therefore combinational. Only the hold
//   counter, the force flag and the optional statistics counter are state.
//
// Parameters:
//   DATA_W    - data bus width
//   RAMSIZE   - RAM address width
//   MAX_HOLD  - maximum consecutive DMA-owned cycles (1..255)
//
// Ports:
//   clk, reset                          - system clock, synchronous active-high reset
//   cpu_address/cpu_wdata/cpu_rnw       - CPU side of the RAM access
//   cpu_ram_cs_b                        - decoded CPU RAM select, active-low
//   cpu_clken                           - CPU clock enable, 0 stalls the CPU
//   dma_req/dma_address/dma_wdata/dma_rnw - DMA access request
//   dma_ack                             - DMA access performed this cycle
//   dma_rdata                           - RAM read data passed through to the DMA
//   ram_address/ram_din/ram_rnw/ram_cs_b - RAM port
//   ram_dout                            - RAM read data
//   stall_count                         - cycles the CPU wanted RAM but was stalled
//
// Configuration:
//   ARB_STATS_EN - when defined, stall_count is a saturating counter of cycles
//                  with cpu_clken=0 and cpu_ram_cs_b=0. When undefined the
//                  counter is absent and stall_count is tied to zero.
// -----------------------------------------------------------------------------
module opc_ram_arbiter #(
    parameter int DATA_W   = 16,
    parameter int RAMSIZE  = 12,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               reset,

    input  logic [RAMSIZE-1:0] cpu_address,
    input  logic [DATA_W-1:0]  cpu_wdata,
    input  logic               cpu_rnw,
    input  logic               cpu_ram_cs_b,
    output logic               cpu_clken,

    input  logic               dma_req,
    input  logic [RAMSIZE-1:0] dma_address,
    input  logic [DATA_W-1:0]  dma_wdata,
    input  logic               dma_rnw,
    output logic               dma_ack,
    output logic [DATA_W-1:0]  dma_rdata,

    output logic [RAMSIZE-1:0] ram_address,
    output logic [DATA_W-1:0]  ram_din,
    output logic               ram_rnw,
    output logic               ram_cs_b,
    input  logic [DATA_W-1:0]  ram_dout,

    output logic [15:0]        stall_count
);

    // The hold counter is 8 bits wide, which bounds MAX_HOLD to 255.
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    logic       force_cpu_r;   // next cycle is handed to the CPU regardless of dma_req
    logic [7:0] hold_cnt_r;    // consecutive DMA-owned cycles so far
    logic       dma_own_s;     // this cycle belongs to the DMA
    logic [7:0] hold_next_s;   // hold count including the current DMA cycle
    logic       hold_hit_s;    // current DMA cycle reaches the hold limit

    // Cycle ownership: reset blocks the DMA so the in-flight access is not acked.
    always_comb begin
        dma_own_s   = dma_req & ~force_cpu_r & ~reset;
        hold_next_s = hold_cnt_r + 8'd1;
        hold_hit_s  = (hold_next_s == HOLD_LIMIT);
    end

    // RAM port mux and handshake outputs, selected by the cycle owner.
    always_comb begin
        dma_rdata = ram_dout;
        if (dma_own_s) begin
            ram_address = dma_address;
            ram_din     = dma_wdata;
            ram_rnw     = dma_rnw;
            ram_cs_b    = 1'b0;
            dma_ack     = 1'b1;
            cpu_clken   = 1'b0;
        end else begin
            // CPU cycle: with cpu_ram_cs_b=1 the RAM is deselected, so no
            // stray write can happen even if cpu_rnw is low.
            ram_address = cpu_address;
            ram_din     = cpu_wdata;
            ram_rnw     = cpu_rnw;
            ram_cs_b    = cpu_ram_cs_b;
            dma_ack     = 1'b0;
            cpu_clken   = 1'b1;
        end
    end

    // Hold-limit tracking: count DMA cycles, force one CPU cycle at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_r  <= 8'd0;
            force_cpu_r <= 1'b0;
        end else if (dma_own_s) begin
            if (hold_hit_s) begin
                // Limit reached: the next cycle goes to the CPU and the burst
                // count restarts from zero afterwards.
                hold_cnt_r  <= 8'd0;
                force_cpu_r <= 1'b1;
            end else begin
                hold_cnt_r  <= hold_next_s;
                force_cpu_r <= 1'b0;
            end
        end else begin
            // Any CPU-owned cycle (including the forced one) ends the burst,
            // so the force flag never lasts more than one cycle.
            hold_cnt_r  <= 8'd0;
            force_cpu_r <= 1'b0;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] stall_cnt_r;
    logic        stall_evt_s;

    // A stall only counts when the CPU actually wanted the RAM that cycle.
    always_comb begin
        stall_evt_s = ~cpu_clken & ~cpu_ram_cs_b;
    end

    // Saturating stall counter, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 16'h0000;
        end else if (stall_evt_s && (stall_cnt_r != 16'hffff)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_count = stall_cnt_r;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_opc_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_opc_ram_arbiter
//
// Table-driven bench for opc_ram_arbiter. Each vector holds one cycle of
// inputs plus the expected DMA acknowledge; the remaining expectations
// (clock enable, RAM port contents, stall count) are derived from that.
// Expected values are pushed to a scoreboard queue when a vector is driven
// and popped/compared once the outputs of that cycle have settled (after the
// falling-edge RAM model has produced its read data).
//
// u_dut  : MAX_HOLD=4, attached to a falling-edge RAM model.
// u_dut1 : MAX_HOLD=1, shares the inputs, only its dma_ack is checked.
// -----------------------------------------------------------------------------
module tb_opc_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] cpu_address;
    logic [15:0] cpu_wdata;
    logic        cpu_rnw;
    logic        cpu_ram_cs_b;
    logic        cpu_clken;
    logic        dma_req;
    logic [11:0] dma_address;
    logic [15:0] dma_wdata;
    logic        dma_rnw;
    logic        dma_ack;
    logic [15:0] dma_rdata;
    logic [11:0] ram_address;
    logic [15:0] ram_din;
    logic        ram_rnw;
    logic        ram_cs_b;
    logic [15:0] ram_dout = 16'h0000;
    logic [15:0] stall_count;

    logic        u1_cpu_clken;
    logic        u1_dma_ack;
    logic [15:0] u1_dma_rdata;
    logic [11:0] u1_ram_address;
    logic [15:0] u1_ram_din;
    logic        u1_ram_rnw;
    logic        u1_ram_cs_b;
    logic [15:0] u1_stall_count;

    always #5 clk = ~clk;

    opc_ram_arbiter #(.DATA_W(16), .RAMSIZE(12), .MAX_HOLD(4)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_rnw(cpu_rnw),
        .cpu_ram_cs_b(cpu_ram_cs_b), .cpu_clken(cpu_clken),
        .dma_req(dma_req), .dma_address(dma_address), .dma_wdata(dma_wdata),
        .dma_rnw(dma_rnw), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .ram_address(ram_address), .ram_din(ram_din), .ram_rnw(ram_rnw),
        .ram_cs_b(ram_cs_b), .ram_dout(ram_dout), .stall_count(stall_count)
    );

    opc_ram_arbiter #(.DATA_W(16), .RAMSIZE(12), .MAX_HOLD(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_rnw(cpu_rnw),
        .cpu_ram_cs_b(cpu_ram_cs_b), .cpu_clken(u1_cpu_clken),
        .dma_req(dma_req), .dma_address(dma_address), .dma_wdata(dma_wdata),
        .dma_rnw(dma_rnw), .dma_ack(u1_dma_ack), .dma_rdata(u1_dma_rdata),
        .ram_address(u1_ram_address), .ram_din(u1_ram_din), .ram_rnw(u1_ram_rnw),
        .ram_cs_b(u1_ram_cs_b), .ram_dout(16'h0000), .stall_count(u1_stall_count)
    );

    // Falling-edge single-port RAM model.
    logic [15:0] mem [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    end
    always @(negedge clk) begin
        if (!ram_cs_b) begin
            if (ram_rnw) ram_dout <= mem[ram_address];
            else         mem[ram_address] <= ram_din;
        end
    end

    typedef struct {
        logic        rst;
        logic        ccs;
        logic        crnw;
        logic [11:0] ca;
        logic [15:0] cw;
        logic        req;
        logic        drnw;
        logic [11:0] da;
        logic [15:0] dw;
        logic        ack;
        logic        chk1;
        logic        ack1;
        logic        chk_rd;
        logic [15:0] rd;
    } vec_t;

    typedef struct {
        logic        clken;
        logic        ack;
        logic        cs_b;
        logic [11:0] addr;
        logic        rnw;
        logic [15:0] din;
        logic        chk1;
        logic        ack1;
        logic        chk_rd;
        logic [15:0] rd;
        logic        chk_stall;
        logic [15:0] stall;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_miss = 0;

    function automatic void push_vec(logic rst, logic ccs, logic crnw, logic [11:0] ca,
                                     logic [15:0] cw, logic req, logic drnw, logic [11:0] da,
                                     logic [15:0] dw, logic ack, logic chk1, logic ack1,
                                     logic chk_rd, logic [15:0] rd);
        vec_t v;
        v.rst = rst; v.ccs = ccs; v.crnw = crnw; v.ca = ca; v.cw = cw;
        v.req = req; v.drnw = drnw; v.da = da; v.dw = dw; v.ack = ack;
        v.chk1 = chk1; v.ack1 = ack1; v.chk_rd = chk_rd; v.rd = rd;
        vecs.push_back(v);
    endfunction

    function automatic void v_rst();
        push_vec(1'b1, 1'b1, 1'b1, 12'h000, 16'h0000, 1'b0, 1'b1, 12'h000, 16'h0000,
                 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endfunction

    function automatic void v_cpu(logic ccs, logic crnw, logic [11:0] ca, logic [15:0] cw,
                                  logic chk_rd, logic [15:0] rd);
        push_vec(1'b0, ccs, crnw, ca, cw, 1'b0, 1'b1, 12'h000, 16'h0000,
                 1'b0, 1'b0, 1'b0, chk_rd, rd);
    endfunction

    function automatic void v_dma(logic drnw, logic [11:0] da, logic [15:0] dw, logic ack,
                                  logic ccs, logic chk_rd, logic [15:0] rd);
        push_vec(1'b0, ccs, 1'b1, 12'h010, 16'h0000, 1'b1, drnw, da, dw,
                 ack, 1'b0, 1'b0, chk_rd, rd);
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] got, logic [31:0] exp);
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, idx, got, exp);
        end
    endtask

    initial begin
        logic [11:0] pat10;
        logic [4:0]  pat_a;
        logic [4:0]  pat_b;
        logic [15:0] stall_m;
        logic        seen_rst;
        int          k;
        vec_t        v;
        exp_t        e;
        exp_t        g;

        // ---- reset ----
        v_rst(); v_rst();
        // ---- idle: CPU write then read back ----
        v_cpu(1'b0, 1'b0, 12'h010, 16'h1234, 1'b0, 16'h0000);
        v_cpu(1'b0, 1'b1, 12'h010, 16'h0000, 1'b1, 16'h1234);
        // ---- single DMA write, one ack, then CPU read ----
        v_dma(1'b0, 12'h020, 16'hbeef, 1'b1, 1'b1, 1'b0, 16'h0000);
        v_cpu(1'b1, 1'b1, 12'h000, 16'h0000, 1'b0, 16'h0000);
        v_cpu(1'b0, 1'b1, 12'h020, 16'h0000, 1'b1, 16'hbeef);
        // ---- single DMA read of the same location ----
        v_dma(1'b1, 12'h020, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hbeef);
        v_cpu(1'b1, 1'b1, 12'h000, 16'h0000, 1'b0, 16'h0000);
        // ---- MAX_HOLD=4 burst of 10 writes: ack 1111 0 1111 0 11 ----
        pat10 = 12'b1111_0_1111_0_11;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            v_dma(1'b0, 12'h100 + 12'(k), 16'ha000 + 16'(k), pat10[11-c], 1'b1,
                  1'b0, 16'h0000);
            if (pat10[11-c]) k++;
        end
        v_cpu(1'b1, 1'b1, 12'h000, 16'h0000, 1'b0, 16'h0000);
        for (int a = 0; a < 10; a++)
            v_cpu(1'b0, 1'b1, 12'h100 + 12'(a), 16'h0000, 1'b1, 16'ha000 + 16'(a));
        // ---- same request stream seen by MAX_HOLD=4 and MAX_HOLD=1 ----
        v_rst();
        pat_a = 5'b11110;
        pat_b = 5'b10101;
        for (int c = 0; c < 5; c++)
            push_vec(1'b0, 1'b1, 1'b1, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h020, 16'h0000,
                     pat_a[4-c], 1'b1, pat_b[4-c], pat_a[4-c], 16'hbeef);
        push_vec(1'b0, 1'b1, 1'b1, 12'h000, 16'h0000, 1'b0, 1'b1, 12'h000, 16'h0000,
                 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        // ---- reset on the third access of a burst; burst restarts afterwards ----
        v_dma(1'b0, 12'h200, 16'hc000, 1'b1, 1'b1, 1'b0, 16'h0000);
        v_dma(1'b0, 12'h201, 16'hc001, 1'b1, 1'b1, 1'b0, 16'h0000);
        push_vec(1'b1, 1'b1, 1'b1, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h202, 16'hc002,
                 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        v_dma(1'b0, 12'h202, 16'hc002, 1'b1, 1'b1, 1'b0, 16'h0000);
        v_dma(1'b0, 12'h203, 16'hc003, 1'b1, 1'b1, 1'b0, 16'h0000);
        v_dma(1'b0, 12'h204, 16'hc004, 1'b1, 1'b1, 1'b0, 16'h0000);
        v_dma(1'b0, 12'h205, 16'hc005, 1'b1, 1'b1, 1'b0, 16'h0000);
        // fourth cycle after reset hit the limit, so the next one is the CPU's
        v_dma(1'b0, 12'h206, 16'hc006, 1'b0, 1'b1, 1'b0, 16'h0000);
        v_dma(1'b0, 12'h206, 16'hc006, 1'b1, 1'b1, 1'b0, 16'h0000);
        v_cpu(1'b0, 1'b1, 12'h202, 16'h0000, 1'b1, 16'hc002);
        v_cpu(1'b0, 1'b1, 12'h206, 16'h0000, 1'b1, 16'hc006);
        // ---- stall statistics: 6 DMA cycles with the CPU selecting RAM ----
        v_rst();
        pat10 = 12'b1111_0_11_00000;
        k = 0;
        for (int c = 0; c < 7; c++) begin
            v_dma(1'b0, 12'h300 + 12'(k), 16'hd000 + 16'(k), pat10[11-c], 1'b0,
                  1'b0, 16'h0000);
            if (pat10[11-c]) k++;
        end
        v_cpu(1'b1, 1'b1, 12'h000, 16'h0000, 1'b0, 16'h0000);
        v_cpu(1'b1, 1'b1, 12'h000, 16'h0000, 1'b0, 16'h0000);
        v_rst();
        v_cpu(1'b1, 1'b1, 12'h000, 16'h0000, 1'b0, 16'h0000);

        // ---- apply ----
        stall_m  = 16'h0000;
        seen_rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            reset        = v.rst;
            cpu_ram_cs_b = v.ccs;
            cpu_rnw      = v.crnw;
            cpu_address  = v.ca;
            cpu_wdata    = v.cw;
            dma_req      = v.req;
            dma_rnw      = v.drnw;
            dma_address  = v.da;
            dma_wdata    = v.dw;

            e.clken     = ~v.ack;
            e.ack       = v.ack;
            e.cs_b      = v.ack ? 1'b0 : v.ccs;
            e.addr      = v.ack ? v.da : v.ca;
            e.rnw       = v.ack ? v.drnw : v.crnw;
            e.din       = v.ack ? v.dw : v.cw;
            e.chk1      = v.chk1;
            e.ack1      = v.ack1;
            e.chk_rd    = v.chk_rd;
            e.rd        = v.rd;
            e.chk_stall = seen_rst;
            e.stall     = stall_m;
            sb.push_back(e);

`ifdef ARB_STATS_EN
            if (v.rst) stall_m = 16'h0000;
            else if (v.ack && !v.ccs && stall_m != 16'hffff) stall_m = stall_m + 16'h0001;
`endif
            if (v.rst) seen_rst = 1'b1;

            @(negedge clk);
            #2;
            g = sb.pop_front();
            n_vec++;
            chk("cpu_clken", i, 32'(cpu_clken), 32'(g.clken));
            chk("dma_ack", i, 32'(dma_ack), 32'(g.ack));
            chk("ram_cs_b", i, 32'(ram_cs_b), 32'(g.cs_b));
            if (!g.cs_b) begin
                chk("ram_address", i, 32'(ram_address), 32'(g.addr));
                chk("ram_rnw", i, 32'(ram_rnw), 32'(g.rnw));
                if (!g.rnw) chk("ram_din", i, 32'(ram_din), 32'(g.din));
            end
            if (g.chk_rd) chk("rdata", i, 32'(dma_rdata), 32'(g.rd));
            if (g.chk1) chk("ack_maxhold1", i, 32'(u1_dma_ack), 32'(g.ack1));
            if (g.chk_stall) chk("stall_count", i, 32'(stall_count), 32'(g.stall));
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
